flip_detect_scheduler: RTL

//  Time-multiplexes one Mealy bit-flip (0->1 / 1->0) detector across NUM_LANES serial lanes.
//  A round-robin scheduler visits each enabled lane for PASSES passes per start command.

---
 rtl/flip_sched_pkg.sv | 25 ++
 rtl/flip_detect_scheduler_hist.sv | 31 +++
 rtl/flip_detect_scheduler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/flip_sched_pkg.sv
// Shared encodings for the time-multiplexed flip detector: lane history, scheduler
// states and event direction.
package flip_sched_pkg;

  typedef enum logic [1:0] {
    HIST_0   = 2'b00,
    HIST_1   = 2'b01,
    HIST_UNK = 2'b11
  } hist_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SCAN   = 2'b01,
    STALL  = 2'b10,
    FINISH = 2'b11
  } state_t;

  localparam logic DIR_RISE = 1'b1;
  localparam logic DIR_FALL = 1'b0;

  function automatic hist_t hist_of(input logic b);
    return b ? HIST_1 : HIST_0;
  endfunction

endpackage

// File: rtl/flip_detect_scheduler_hist.sv
// One lane's last-bit history plus the Mealy compare that flags a flip on the
// current sample.
module flip_lane_hist
  import flip_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic sample_en,
  input  logic clear,
  output logic flip,
  output logic dir
);

  hist_t hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= HIST_UNK;
    end else if (clear) begin
      hist <= HIST_UNK;
    end else if (sample_en) begin
      hist <= hist_of(sample);
    end
  end

  // UNK never reports: the first sample after a clear only seeds the history.
  assign flip = sample_en && (hist != HIST_UNK) && (hist[0] != sample);
  assign dir  = sample ? DIR_RISE : DIR_FALL;

endmodule

// File: rtl/flip_detect_scheduler.sv
// Round-robin scheduler sharing one flip detector over NUM_LANES serial lanes.
// Optional per-lane saturating flip counters are built when FLIP_COUNT_EN is defined.
module flip_detect_scheduler
  import flip_sched_pkg::*;
#(
  parameter  int unsigned NUM_LANES = 4,
  parameter  int unsigned PASSES    = 8
`ifdef FLIP_COUNT_EN
  ,
  parameter  int unsigned CNT_W     = 8
`endif
  ,
  localparam int unsigned LANE_W    = $clog2(NUM_LANES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] ser_in,
  input  logic [NUM_LANES-1:0] lane_en,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [LANE_W-1:0]    evt_lane,
  output logic                 evt_dir
`ifdef FLIP_COUNT_EN
  ,
  input  logic [LANE_W-1:0]    cnt_sel,
  output logic [CNT_W-1:0]     cnt_out
`endif
);

  localparam int unsigned PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

  state_t                 state;
  logic [NUM_LANES-1:0]   mask;
  logic [LANE_W-1:0]      ptr;
  logic [PASS_W-1:0]      pass_cnt;

  logic                   slot_free;
  logic                   scan_fire;
  logic                   start_acc;
  logic [LANE_W-1:0]      nxt_ptr;
  logic                   wrap;
  logic                   flip_now;
  logic                   dir_now;
  logic [NUM_LANES-1:0]   flip_vec;
  logic [NUM_LANES-1:0]   dir_vec;

  function automatic logic [LANE_W-1:0] first_lane(input logic [NUM_LANES-1:0] m);
    logic [LANE_W-1:0] r;
    r = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (m[LANE_W'(i)]) r = LANE_W'(i);
    end
    return r;
  endfunction

  // Nearest enabled lane after p, cyclically; p itself when it is the only one.
  function automatic logic [LANE_W-1:0] next_lane(input logic [NUM_LANES-1:0] m,
                                                  input logic [LANE_W-1:0]    p);
    logic [LANE_W-1:0] r;
    int unsigned       idx;
    r = p;
    for (int k = NUM_LANES; k >= 1; k--) begin
      idx = (32'(p) + 32'(k)) % NUM_LANES;
      if (m[LANE_W'(idx)]) r = LANE_W'(idx);
    end
    return r;
  endfunction

  always_comb begin
    slot_free = !evt_valid || evt_ready;
    scan_fire = (state == SCAN) && slot_free;
    start_acc = (state == IDLE) && start && (lane_en != '0);
    nxt_ptr   = next_lane(mask, ptr);
    wrap      = (nxt_ptr <= ptr);
    flip_now  = flip_vec[ptr];
    dir_now   = dir_vec[ptr];
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    flip_lane_hist u_hist (
      .clk       (clk),
      .rst       (rst),
      .sample    (ser_in[i]),
      .sample_en (scan_fire && (ptr == LANE_W'(i))),
      .clear     (start_acc),
      .flip      (flip_vec[i]),
      .dir       (dir_vec[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      evt_valid <= 1'b0;
      evt_lane  <= '0;
      evt_dir   <= 1'b0;
      mask      <= '0;
      ptr       <= '0;
      pass_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (lane_en != '0) begin
              mask     <= lane_en;
              ptr      <= first_lane(lane_en);
              pass_cnt <= '0;
              busy     <= 1'b1;
              state    <= SCAN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (slot_free) begin
            // A new event may replace one being accepted this same cycle.
            if (flip_now) begin
              evt_valid <= 1'b1;
              evt_lane  <= ptr;
              evt_dir   <= dir_now;
            end else begin
              evt_valid <= 1'b0;
            end
            ptr <= nxt_ptr;
            if (wrap) begin
              if (pass_cnt == PASS_W'(PASSES - 1)) begin
                state <= FINISH;
              end else begin
                pass_cnt <= pass_cnt + PASS_W'(1);
              end
            end
          end else begin
            state <= STALL;
          end
        end
        STALL: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= SCAN;
          end
        end
        FINISH: begin
          if (slot_free) begin
            evt_valid <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FLIP_COUNT_EN
  logic [CNT_W-1:0] cnt [NUM_LANES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) cnt[i] <= '0;
    end else if (start_acc) begin
      for (int i = 0; i < NUM_LANES; i++) cnt[i] <= '0;
    end else if (scan_fire && flip_now && (cnt[ptr] != '1)) begin
      cnt[ptr] <= cnt[ptr] + CNT_W'(1);
    end
  end

  always_comb begin
    cnt_out = '0;
    if (32'(cnt_sel) < NUM_LANES) cnt_out = cnt[cnt_sel];
  end
`endif

endmodule
